// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: default widths, reset PC and NOP encoding.
package inst_fetch_unit_pkg;

    localparam int unsigned PC_BITS_DEF        = 8;
    localparam int unsigned INST_BITS_DEF      = 16;
    localparam int unsigned INST_MEM_DEPTH_DEF = 32;
    localparam int unsigned FIFO_DEPTH_DEF     = 3;
    localparam int unsigned RESET_PC_DEF       = 0;
    localparam int unsigned ADDR_BITS_DEF      = $clog2(INST_MEM_DEPTH_DEF);

    // Encoding substituted for words fetched beyond the end of instruction memory
    localparam int unsigned NOP_INST = 0;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle of the fetch unit: PC register feed, instruction memory port, redirect and
// decode handshake. Signal names are seen from the fetch unit (o_ = driven by it).
interface inst_fetch_unit_if
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned PC_BITS   = PC_BITS_DEF,
    parameter int unsigned INST_BITS = INST_BITS_DEF,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF
) ();

    logic [PC_BITS-1:0]   o_pc_next;
    logic                 o_imem_en;
    logic [ADDR_BITS-1:0] o_imem_addr;
    logic [INST_BITS-1:0] i_imem_data;
    logic                 i_redirect;
    logic [PC_BITS-1:0]   i_redirect_pc;
    logic                 o_inst_valid;
    logic                 i_inst_ready;
    logic [INST_BITS-1:0] o_inst;
    logic [PC_BITS-1:0]   o_inst_pc;
    logic                 o_inst_oor;

    modport master (
        output o_pc_next, o_imem_en, o_imem_addr,
        input  i_imem_data,
        input  i_redirect, i_redirect_pc,
        output o_inst_valid,
        input  i_inst_ready,
        output o_inst, o_inst_pc, o_inst_oor
    );

    modport slave (
        input  o_pc_next, o_imem_en, o_imem_addr,
        output i_imem_data,
        output i_redirect, i_redirect_pc,
        input  o_inst_valid,
        output i_inst_ready,
        input  o_inst, o_inst_pc, o_inst_oor
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding fetched {oor, pc, inst} entries. Supports simultaneous
// push and pop, a synchronous flush, and reports its occupancy.
module inst_fetch_unit_fetch_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 3,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and occupancy
    always_comb begin
        do_pop   = i_pop && (count_q != '0);
        do_push  = i_push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and count registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while count is zero
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single-cycle reads to instruction memory, buffers
// returned words with their PC and hands them to decode over valid/ready. A redirect
// reloads the fetch PC and discards everything buffered or in flight.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned PC_BITS        = PC_BITS_DEF,
    parameter int unsigned INST_BITS      = INST_BITS_DEF,
    parameter int unsigned INST_MEM_DEPTH = INST_MEM_DEPTH_DEF,
    parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned RESET_PC       = RESET_PC_DEF,
    localparam int unsigned ADDR_BITS     = $clog2(INST_MEM_DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    inst_fetch_unit_if.master bus
);

    localparam int unsigned ENTRY_W = INST_BITS + PC_BITS + 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic [PC_BITS-1:0]   fpc_q, fpc_d;
    logic                 inflight_q, inflight_d;
    logic [PC_BITS-1:0]   tag_q, tag_d;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 inst_valid;
    logic                 tag_oor;
    logic [INST_BITS-1:0] push_inst;
    logic [ENTRY_W-1:0]   wdata;
    logic [ENTRY_W-1:0]   rdata;
    logic [CNT_W-1:0]     count;

    // Issue decision, memory response capture and decode handshake
    always_comb begin
        // Registered occupancy only: a pop this cycle does not free a slot for issue
        issue      = !i_rst && !bus.i_redirect &&
                     ((32'(count) + 32'(inflight_q)) < FIFO_DEPTH);
        tag_oor    = (32'(tag_q) >= INST_MEM_DEPTH);
        push_inst  = tag_oor ? INST_BITS'(NOP_INST) : bus.i_imem_data;
        wdata      = {tag_oor, tag_q, push_inst};
        push       = inflight_q && !i_rst && !bus.i_redirect;
        inst_valid = (count != '0) && !i_rst;
        pop        = inst_valid && bus.i_inst_ready && !bus.i_redirect;
    end

    // Next fetch PC, in-flight flag and tag of the outstanding read
    always_comb begin
        fpc_d      = fpc_q;
        inflight_d = issue;
        tag_d      = tag_q;
        if (bus.i_redirect) begin
            fpc_d = bus.i_redirect_pc;
        end else if (issue) begin
            fpc_d = fpc_q + 1'b1;
            tag_d = fpc_q;
        end
    end

    // Fetch state registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fpc_q      <= PC_BITS'(RESET_PC);
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    inst_fetch_unit_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (bus.i_redirect),
        .i_push  (push),
        .i_wdata (wdata),
        .i_pop   (pop),
        .o_rdata (rdata),
        .o_count (count)
    );

    assign bus.o_pc_next    = fpc_q;
    assign bus.o_imem_en    = issue;
    assign bus.o_imem_addr  = fpc_q[ADDR_BITS-1:0];
    assign bus.o_inst_valid = inst_valid;
    assign bus.o_inst       = rdata[INST_BITS-1:0];
    assign bus.o_inst_pc    = rdata[INST_BITS +: PC_BITS];
    assign bus.o_inst_oor   = rdata[ENTRY_W-1];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: 1-cycle imem model (mem[k] = 16'h1000 + k), a cycle table for
// reset/stream/stall behaviour, a scoreboard checking every delivered word, and hand-written
// redirect/wrap/mid-stream-reset sequences.
module tb_inst_fetch_unit;

    logic clk;
    logic rst;

    inst_fetch_unit_if bus ();

    inst_fetch_unit u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (bus.o_imem_en === 1'b1) bus.i_imem_data <= 16'h1000 + 16'(bus.o_imem_addr);
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of words expected at the decode port, in program order
    typedef struct {
        logic [15:0] inst;
        logic [7:0]  pc;
        logic        oor;
    } sb_t;

    sb_t        sb_q[$];
    logic [7:0] model_pc = 8'h00;

    always @(negedge clk) begin
        sb_t e;
        if (rst === 1'b1) begin
            sb_q.delete();
            model_pc = 8'h00;
        end else begin
            chk("pc_next", 32'(bus.o_pc_next), 32'(model_pc));
            if (bus.i_redirect) chk("en_on_redirect", 32'(bus.o_imem_en), 32'd0);
            if (bus.o_imem_en === 1'b1) begin
                chk("imem_addr", 32'(bus.o_imem_addr), 32'(model_pc[4:0]));
                e.pc   = model_pc;
                e.oor  = (model_pc >= 8'd32);
                e.inst = e.oor ? 16'h0000 : 16'h1000 + 16'(model_pc[4:0]);
                sb_q.push_back(e);
            end
            if (bus.o_inst_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'(bus.o_inst_pc), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_inst", 32'(bus.o_inst), 32'(sb_q[0].inst));
                    chk("sb_pc", 32'(bus.o_inst_pc), 32'(sb_q[0].pc));
                    chk("sb_oor", 32'(bus.o_inst_oor), 32'(sb_q[0].oor));
                    if (bus.i_inst_ready && !bus.i_redirect) void'(sb_q.pop_front());
                end
            end
            if (bus.i_redirect) begin
                sb_q.delete();
                model_pc = bus.i_redirect_pc;
            end else if (bus.o_imem_en === 1'b1) begin
                model_pc = model_pc + 8'd1;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, return at the falling edge
    task automatic apply(input logic r, input logic rdy, input logic redir, input logic [7:0] rpc);
        @(posedge clk);
        #1;
        rst               = r;
        bus.i_inst_ready  = rdy;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst;
        logic       ready;
        logic       exp_en;
        logic       exp_valid;
        logic       chk_pc;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic en, input logic v,
                                input logic cp, input logic [7:0] pc);
        vec_t x;
        x.rst = r; x.ready = rdy; x.exp_en = en; x.exp_valid = v; x.chk_pc = cp; x.exp_pc = pc;
        return x;
    endfunction

    initial begin
        rst               = 1'b1;
        bus.i_inst_ready  = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 8'h00;

        // Reset then free-running stream
        vecs.push_back(mk(1, 1, 0, 0, 0, 8'd0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 8'd0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 8'd0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 8'd1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 8'd2));
        vecs.push_back(mk(0, 1, 1, 1, 1, 8'd3));
        vecs.push_back(mk(0, 1, 1, 1, 1, 8'd4));
        // Reset then stalled decode: three fetches fill the buffer, then resume
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'd0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 8'd0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'd0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 8'd1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 8'd2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8'd3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8'd3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 8'd3));
        vecs.push_back(mk(0, 1, 0, 1, 1, 8'd3));
        vecs.push_back(mk(0, 1, 1, 1, 1, 8'd3));
        vecs.push_back(mk(0, 1, 1, 1, 1, 8'd4));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].ready, 1'b0, 8'h00);
            chk($sformatf("tbl%0d_en", i), 32'(bus.o_imem_en), 32'(vecs[i].exp_en));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.o_inst_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_pc)
                chk($sformatf("tbl%0d_pc_next", i), 32'(bus.o_pc_next), 32'(vecs[i].exp_pc));
        end

        // Redirect with two words buffered and one in flight
        apply(1, 0, 0, 8'h00);
        apply(1, 0, 0, 8'h00);
        repeat (3) apply(0, 0, 0, 8'h00);
        apply(0, 0, 1, 8'h10);
        chk("redir10_en", 32'(bus.o_imem_en), 32'd0);
        apply(0, 1, 0, 8'h00);
        chk("redir10_valid_r1", 32'(bus.o_inst_valid), 32'd0);
        chk("redir10_pc_next", 32'(bus.o_pc_next), 32'h10);
        chk("redir10_en_r1", 32'(bus.o_imem_en), 32'd1);
        apply(0, 1, 0, 8'h00);
        chk("redir10_valid_r2", 32'(bus.o_inst_valid), 32'd0);
        apply(0, 1, 0, 8'h00);
        chk("redir10_valid_r3", 32'(bus.o_inst_valid), 32'd1);
        chk("redir10_pc", 32'(bus.o_inst_pc), 32'h10);
        chk("redir10_inst", 32'(bus.o_inst), 32'h1010);

        // End of instruction memory
        apply(0, 1, 1, 8'h1F);
        apply(0, 1, 0, 8'h00);
        chk("redir1f_valid_r1", 32'(bus.o_inst_valid), 32'd0);
        apply(0, 1, 0, 8'h00);
        apply(0, 1, 0, 8'h00);
        chk("redir1f_valid", 32'(bus.o_inst_valid), 32'd1);
        chk("redir1f_pc", 32'(bus.o_inst_pc), 32'h1F);
        chk("redir1f_inst", 32'(bus.o_inst), 32'h101F);
        chk("redir1f_oor", 32'(bus.o_inst_oor), 32'd0);
        apply(0, 1, 0, 8'h00);
        chk("pc20_pc", 32'(bus.o_inst_pc), 32'h20);
        chk("pc20_inst", 32'(bus.o_inst), 32'h0000);
        chk("pc20_oor", 32'(bus.o_inst_oor), 32'd1);

        // PC wrap 0xFF -> 0x00, then reset mid-stream
        apply(0, 1, 1, 8'hFF);
        apply(0, 1, 0, 8'h00);
        apply(0, 1, 0, 8'h00);
        apply(0, 1, 0, 8'h00);
        chk("pcff_valid", 32'(bus.o_inst_valid), 32'd1);
        chk("pcff_pc", 32'(bus.o_inst_pc), 32'hFF);
        chk("pcff_oor", 32'(bus.o_inst_oor), 32'd1);
        chk("pcff_inst", 32'(bus.o_inst), 32'h0000);
        apply(0, 1, 0, 8'h00);
        chk("pc00_pc", 32'(bus.o_inst_pc), 32'h00);
        chk("pc00_oor", 32'(bus.o_inst_oor), 32'd0);
        chk("pc00_inst", 32'(bus.o_inst), 32'h1000);
        apply(1, 1, 0, 8'h00);
        chk("midrst_valid", 32'(bus.o_inst_valid), 32'd0);
        chk("midrst_en", 32'(bus.o_imem_en), 32'd0);
        apply(1, 1, 0, 8'h00);
        chk("midrst_pc_next", 32'(bus.o_pc_next), 32'h00);
        chk("midrst_valid2", 32'(bus.o_inst_valid), 32'd0);
        apply(0, 1, 0, 8'h00);
        chk("postrst_en", 32'(bus.o_imem_en), 32'd1);
        chk("postrst_addr", 32'(bus.o_imem_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
